// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed 7-seg scan with frame-boundary load handshake; define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dot_mask,
    input  logic                  load,
    output logic                  load_ack,
    output logic [3:0]            bcd,
    output logic                  dp,
    output logic                  blank,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_start
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dot;
    logic [3:0]            nib [DIGITS];
    logic                  tick, last, frame_edge;

    assign tick       = pre == PW'(SCAN_DIV - 1);
    assign last       = idx == IW'(DIGITS - 1);
    assign frame_edge = tick && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dot <= '0;
            load_ack   <= 1'b0;
        end else begin
            pre      <= tick ? '0 : pre + 1'b1;
            idx      <= tick ? (last ? '0 : idx + 1'b1) : idx;
            load_ack <= frame_edge && load;
            if (frame_edge && load) begin
                shadow_val <= value;
                shadow_dot <= dot_mask;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign nib[g] = shadow_val[4*g +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // hi_zero[g]: every nibble from g up to the leftmost digit is zero
    logic [DIGITS-1:0] hi_zero;
    for (genvar g = 0; g < DIGITS; g++) begin : g_hz
        assign hi_zero[g] = ~|shadow_val[4*DIGITS-1:4*g];
    end
    assign blank = (idx != '0) && hi_zero[idx];
`else
    assign blank = 1'b0;
`endif

    assign bcd         = nib[idx];
    assign dp          = shadow_dot[idx] & ~blank;
    assign frame_start = (idx == '0) && (pre == '0);

    always_comb begin
        digit_sel = '1;
        if (pre >= PW'(DEAD_CYCLES) && !blank) digit_sel[idx] = 1'b0;
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: randomized self-checking bench against a cycle-count reference model.
module tb_seven_seg_scan_ctrl;
    localparam int DIGITS = 4, SCAN_DIV = 4, DEAD = 1;
    localparam int FRAME = DIGITS * SCAN_DIV;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dot_mask = '0;
    logic        load_ack, dp, blank, frame_start;
    logic [3:0]  bcd, digit_sel;

    int vectors = 0, errs = 0;
    int n;
    logic [15:0] m_val;
    logic [3:0]  m_dot;
    logic        m_ack;

    seven_seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dot_mask(dot_mask), .load(load),
        .load_ack(load_ack), .bcd(bcd), .dp(dp), .blank(blank),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] RESET_OBS = {1'b0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};

    function automatic logic [11:0] observed();
        return {load_ack, bcd, dp, blank, digit_sel, frame_start};
    endfunction

    // Expected outputs for cycle n since reset release, from slot arithmetic.
    function automatic logic [11:0] expected();
        int pre = n % SCAN_DIV;
        int idx = (n / SCAN_DIV) % DIGITS;
        logic [15:0] sh = m_val >> (4 * idx);
        logic bl, d;
        logic [3:0] sel;
`ifdef LEADING_ZERO_BLANK_EN
        bl = (idx != 0) && (sh == 16'h0);
`else
        bl = 1'b0;
`endif
        d   = m_dot[idx] && !bl;
        sel = (pre >= DEAD && !bl) ? ~(4'b0001 << idx) : 4'hF;
        return {m_ack, sh[3:0], d, bl, sel, n % FRAME == 0};
    endfunction

    task automatic advance();
        m_ack = (n % FRAME == FRAME - 1) && load;
        if (m_ack) begin
            m_val = value;
            m_dot = dot_mask;
        end
        n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_val = '0; m_dot = '0; m_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 vectors++;
        if (observed() !== RESET_OBS) begin
            errs++; $display("FAIL reset_async got %h want %h", observed(), RESET_OBS);
        end
        do_reset();
        #1 vectors++;
        if (observed() !== RESET_OBS) begin
            errs++; $display("FAIL reset_release got %h want %h", observed(), RESET_OBS);
        end
    endtask

    task automatic test_scan();
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            value = 16'($urandom); dot_mask = 4'($urandom);
            #1 vectors++;
            if (observed() !== expected()) begin
                errs++; $display("FAIL scan c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_load();
        do_reset();
        value = 16'h1234; dot_mask = 4'b0100;
        for (int c = 0; c < 3 * FRAME; c++) begin
            load = (c >= 3 && c < 16);
            #1 vectors++;
            if (observed() !== expected() || load_ack !== (c == 16)) begin
                errs++; $display("FAIL load c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            load = (c >= 3 && c <= 5);
            value = 16'($urandom) | 16'h1; dot_mask = 4'($urandom);
            #1 vectors++;
            if (observed() !== expected() || load_ack !== 1'b0) begin
                errs++; $display("FAIL withdraw c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
        load = 1'b0;
        #1 vectors++;
        if (m_val !== 16'h0 || bcd !== 4'h0) begin
            errs++; $display("FAIL withdraw_shadow got bcd %h want 0", bcd);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load = 1'b1; dot_mask = 4'b0001;
        for (int c = 0; c < 2 * FRAME + 8; c++) begin
            value = (c < 20) ? 16'h0001 : 16'h0002;
            #1 vectors++;
            if (observed() !== expected() || load_ack !== (c == 16 || c == 32)) begin
                errs++; $display("FAIL back_to_back c=%0d got %h want %h", c, observed(), expected());
            end
            if ((c == 16 || c == 32) && bcd !== ((c == 16) ? 4'h1 : 4'h2)) begin
                errs++; $display("FAIL b2b_bcd c=%0d got %h want %h", c, bcd, (c == 16) ? 4'h1 : 4'h2);
            end
            advance();
        end
        load = 1'b0;
    endtask

    task automatic test_blank();
        do_reset();
        value = 16'h0050; dot_mask = 4'b1111;
        for (int c = 0; c < 3 * FRAME; c++) begin
            load = (c == FRAME - 1);
            #1 vectors++;
            if (observed() !== expected()) begin
                errs++; $display("FAIL blank c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 20 * FRAME; c++) begin
            if (c % 7 == 0) begin
                value = 16'($urandom); dot_mask = 4'($urandom);
                if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
            end
            load = ($urandom_range(0, 3) == 0);
            #1 vectors++;
            if (observed() !== expected()) begin
                errs++; $display("FAIL random c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        value = 16'h9876; dot_mask = 4'b1010;
        for (int c = 0; c <= FRAME + 9; c++) begin
            load = (c < FRAME);
            #1 vectors++;
            if (observed() !== expected()) begin
                errs++; $display("FAIL pre_reset c=%0d got %h want %h", c, observed(), expected());
            end
            if (c < FRAME + 9) advance();
        end
        #1 rst_n = 1'b0;
        #1 vectors++;
        if (observed() !== RESET_OBS) begin
            errs++; $display("FAIL async_reset got %h want %h", observed(), RESET_OBS);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_val = '0; m_dot = '0; m_ack = 1'b0;
        for (int c = 0; c < FRAME + 4; c++) begin
            #1 vectors++;
            if (observed() !== expected()) begin
                errs++; $display("FAIL post_reset c=%0d got %h want %h", c, observed(), expected());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_withdraw();
        test_back_to_back();
        test_blank();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
